// File: rtl/fwuart_pkg.sv
// fwuart_pkg: shared types and helpers for the fwuart transmit-side blocks.
//   state_t   : arbiter FSM states (IDLE, XFER, GAP)
//   idx_width : bits needed to hold an index into n items (minimum 1)
//   cnt_width : bits needed to count from 0 to n inclusive (minimum 1)
package fwuart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fwuart_rr_arb.sv
// fwuart_rr_arb: combinational round-robin pick.
//   req        : request vector, one bit per requester
//   last_grant : index of the most recent winner (lowest priority next)
//   any        : at least one request is set
//   idx        : first set request searching last_grant+1, +2, ... mod N_REQ
module fwuart_rr_arb
    import fwuart_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]             req,
    input  logic [idx_width(N_REQ)-1:0]  last_grant,
    output logic                         any,
    output logic [idx_width(N_REQ)-1:0]  idx
);

    localparam int unsigned IW = idx_width(N_REQ);

    logic [IW-1:0] cand;
    logic          found;

    assign any = |req;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IW'((32'(last_grant) + k) % N_REQ);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwuart_tx_arb.sv
// fwuart_tx_arb: shares one UART transmitter byte port between N_REQ
// byte-stream requesters. A round-robin winner owns the port for a whole
// message, then a forced idle gap precedes the next arbitration. A granted
// requester that stalls for MAX_STALL cycles loses its grant (abort pulse).
//   clock, reset_n : clock and synchronous active-low reset
//   req_data/valid/last, req_ready : per-requester byte streams
//   tx_data/tx_valid/tx_ready      : UART transmitter byte port
//   grant_id : current or most recent grant holder
//   busy     : high while transferring or in the idle gap
//   abort    : one-cycle pulse when a stalled grant is revoked
module fwuart_tx_arb
    import fwuart_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned MAX_STALL  = 1024
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [8*N_REQ-1:0]           req_data,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [idx_width(N_REQ)-1:0]  grant_id,
    output logic                         busy,
    output logic                         abort
);

    localparam int unsigned IW = idx_width(N_REQ);
    localparam int unsigned SW = cnt_width(MAX_STALL);
    localparam int unsigned GW = cnt_width(GAP_CYCLES);

    // Timeout fires on the cycle the stall count would reach MAX_STALL.
    localparam logic [SW-1:0] STALL_LAST = SW'((MAX_STALL == 0) ? 0 : MAX_STALL - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam state_t        END_STATE  = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t         state, state_nx;
    logic [IW-1:0]  grant_q, grant_nx;
    logic [IW-1:0]  last_q, last_nx;
    logic [SW-1:0]  stall_q, stall_nx;
    logic [GW-1:0]  gap_q, gap_nx;

    logic           rr_any;
    logic [IW-1:0]  rr_idx;
    logic [7:0]     data_arr [N_REQ];
    logic           g_valid;
    logic           g_last;

    fwuart_rr_arb #(.N_REQ(N_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .any        (rr_any),
        .idx        (rr_idx)
    );

    for (genvar i = 0; i < N_REQ; i++) begin : g_data
        assign data_arr[i] = req_data[8*i +: 8];
    end

    assign g_valid  = req_valid[grant_q];
    assign g_last   = req_last[grant_q];
    assign tx_data  = data_arr[grant_q];
    assign grant_id = grant_q;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx  = state;
        grant_nx  = grant_q;
        last_nx   = last_q;
        stall_nx  = stall_q;
        gap_nx    = gap_q;
        tx_valid  = 1'b0;
        req_ready = '0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                stall_nx = '0;
                gap_nx   = '0;
                if (rr_any) begin
                    grant_nx = rr_idx;
                    state_nx = XFER;
                end
            end
            XFER: begin
                tx_valid = g_valid;
                req_ready[grant_q] = tx_ready && g_valid;
                if (g_valid) begin
                    stall_nx = '0;
                    if (tx_ready && g_last) begin
                        last_nx  = grant_q;
                        state_nx = END_STATE;
                    end
                end else if (stall_q >= STALL_LAST) begin
                    abort    = 1'b1;
                    last_nx  = grant_q;
                    state_nx = END_STATE;
                end else begin
                    stall_nx = (stall_q == '1) ? stall_q : stall_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q >= GAP_LAST) begin
                    gap_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    gap_nx = gap_q + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            stall_q <= '0;
            gap_q   <= '0;
        end else begin
            state   <= state_nx;
            grant_q <= grant_nx;
            last_q  <= last_nx;
            stall_q <= stall_nx;
            gap_q   <= gap_nx;
        end
    end

endmodule

// File: tb/tb_fwuart_tx_arb.sv
// tb_fwuart_tx_arb: randomized scoreboard bench for fwuart_tx_arb.
// Stimulus queues messages per requester and pushes expected bytes into
// per-requester scoreboards; a negedge monitor runs a transaction-level
// model of grant order, gap length and stall timeout and pops/compares.
module tb_fwuart_tx_arb;

    localparam int N  = 4;
    localparam int G  = 16;
    localparam int MS = 1024;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [1:0]     grant_id;
    logic           busy;
    logic           abort;

    always #5 clock = ~clock;

    fwuart_tx_arb #(.N_REQ(N), .GAP_CYCLES(G), .MAX_STALL(MS)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .abort     (abort)
    );

    int checks = 0;
    int errors = 0;

    // src entry: [9] requester goes silent after this byte, [8] last, [7:0] data
    logic [9:0] src_q [N][$];
    // expected entry: [8] last, [7:0] data
    logic [8:0] exp_q [N][$];

    logic [N-1:0] vld_r;
    logic [N-1:0] stall_en;
    int           bubble_pct;
    int           bp_pct;
    bit           tx_low;
    bit           mon_en;

    // reference model state
    int         m_phase;   // 0 waiting, 1 message, 2 gap
    int         m_last;
    int         m_owner;
    int         m_stall;
    int         m_gap;
    bit         m_first;
    int         abort_seen = 0;
    int         w, c;
    logic [8:0] e;
    logic [31:0] exp_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic push_msg(input int r, input int len, input bit stall_after_first);
        logic [7:0] d;
        for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            src_q[r].push_back({(stall_after_first && b == 0), (b == len - 1), d});
            exp_q[r].push_back({(b == len - 1), d});
        end
    endtask

    task automatic push_bytes3(input int r, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2);
        src_q[r].push_back({2'b00, b0}); exp_q[r].push_back({1'b0, b0});
        src_q[r].push_back({2'b00, b1}); exp_q[r].push_back({1'b0, b1});
        src_q[r].push_back({2'b01, b2}); exp_q[r].push_back({1'b1, b2});
    endtask

    // One clock of requester/transmitter behaviour; inputs change at posedge+1.
    task automatic cycle();
        logic [N-1:0] acc;
        logic [9:0]   h;
        @(negedge clock);
        acc = req_ready;
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (src_q[i].size() > 0) begin
                    h = src_q[i][0];
                    if (h[9]) stall_en[i] = 1'b1;
                    void'(src_q[i].pop_front());
                end
                vld_r[i] = 1'b0;
            end
            if (!vld_r[i] && src_q[i].size() > 0 && !stall_en[i] &&
                $urandom_range(0, 99) >= bubble_pct)
                vld_r[i] = 1'b1;
            req_valid[i] = vld_r[i];
            if (src_q[i].size() > 0) begin
                h = src_q[i][0];
                req_data[8*i +: 8] = h[7:0];
                req_last[i]        = h[8];
            end else begin
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        tx_ready = !tx_low && ($urandom_range(0, 99) >= bp_pct);
    endtask

    task automatic drain();
        int  n;
        bit  pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < 5000) begin
            cycle();
            n++;
            pending = (m_phase != 0);
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) pending = 1'b1;
        end
        chk("drain_timeout", {31'd0, pending}, 32'd0);
    endtask

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (!reset_n) begin
            m_phase = 0;
            m_last  = N - 1;
            m_stall = 0;
            m_first = 0;
        end else if (mon_en) begin
            case (m_phase)
                0: begin
                    chk("idle_busy", 32'(busy), 0);
                    chk("idle_tx_valid", 32'(tx_valid), 0);
                    chk("idle_req_ready", 32'(req_ready), 0);
                    chk("idle_abort", 32'(abort), 0);
                    if (req_valid != 0) begin
                        w = -1;
                        for (int k = 1; k <= N; k++) begin
                            c = (m_last + k) % N;
                            if (w < 0 && req_valid[c]) w = c;
                        end
                        m_owner = w;
                        m_phase = 1;
                        m_first = 1;
                        m_stall = 0;
                    end
                end
                1: begin
                    if (m_first) begin
                        chk("grant_id", 32'(grant_id), 32'(m_owner));
                        m_first = 0;
                    end
                    chk("xfer_busy", 32'(busy), 1);
                    chk("xfer_tx_valid", 32'(tx_valid), 32'(req_valid[m_owner]));
                    exp_rdy = (tx_ready && req_valid[m_owner]) ? (32'd1 << m_owner) : 32'd0;
                    chk("req_ready", 32'(req_ready), exp_rdy);
                    if (tx_valid) begin
                        if (exp_q[m_owner].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_byte: got %0h from req %0d, expected none",
                                     tx_data, m_owner);
                        end else begin
                            e = exp_q[m_owner][0];
                            chk("tx_data", 32'(tx_data), 32'(e[7:0]));
                        end
                    end
                    if (tx_valid && tx_ready) begin
                        m_stall = 0;
                        chk("xfer_abort", 32'(abort), 0);
                        if (exp_q[m_owner].size() > 0) begin
                            e = exp_q[m_owner].pop_front();
                            if (e[8]) begin
                                m_last = m_owner;
                                if (G == 0) m_phase = 0;
                                else begin m_phase = 2; m_gap = G; end
                            end
                        end
                    end else if (!req_valid[m_owner]) begin
                        m_stall++;
                        if (m_stall >= MS) begin
                            chk("abort_pulse", 32'(abort), 1);
                            abort_seen++;
                            exp_q[m_owner].delete();
                            m_last = m_owner;
                            if (G == 0) m_phase = 0;
                            else begin m_phase = 2; m_gap = G; end
                        end else begin
                            chk("stall_abort", 32'(abort), 0);
                        end
                    end else begin
                        m_stall = 0;
                        chk("bp_abort", 32'(abort), 0);
                    end
                end
                default: begin
                    chk("gap_busy", 32'(busy), 1);
                    chk("gap_tx_valid", 32'(tx_valid), 0);
                    chk("gap_req_ready", 32'(req_ready), 0);
                    chk("gap_abort", 32'(abort), 0);
                    m_gap--;
                    if (m_gap <= 0) m_phase = 0;
                end
            endcase
        end
    end

    initial begin
        int start_aborts;
        int n;
        reset_n    = 1'b0;
        req_valid  = '1;
        req_data   = '0;
        req_last   = '0;
        tx_ready   = 1'b1;
        mon_en     = 1'b0;
        vld_r      = '0;
        stall_en   = '0;
        bubble_pct = 0;
        bp_pct     = 0;
        tx_low     = 1'b0;

        // Reset with every requester asking
        repeat (3) begin
            @(negedge clock);
            chk("rst_tx_valid", 32'(tx_valid), 0);
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_grant_id", 32'(grant_id), 0);
        end
        @(posedge clock);
        #1;
        req_valid = '0;
        reset_n   = 1'b1;
        mon_en    = 1'b1;

        // Contention: 0, 1 and 3 at once -> 0, 1, 3
        push_msg(0, 2, 1'b0);
        push_msg(1, 2, 1'b0);
        push_msg(3, 2, 1'b0);
        drain();

        // Single requester, three bytes
        push_bytes3(2, 8'h41, 8'h42, 8'h43);
        drain();

        // Backpressure mid-message
        push_msg(0, 4, 1'b0);
        n = 0;
        while (exp_q[0].size() > 3 && n < 200) begin cycle(); n++; end
        tx_low = 1'b1;
        repeat (200) cycle();
        tx_low = 1'b0;
        drain();

        // Stall timeout: req 1 goes silent after byte 1, req 2 waits
        start_aborts = abort_seen;
        push_msg(1, 3, 1'b1);
        push_msg(2, 1, 1'b0);
        n = 0;
        while (abort_seen == start_aborts && n < 1500) begin cycle(); n++; end
        chk("abort_count", 32'(abort_seen - start_aborts), 1);
        src_q[1].delete();
        stall_en[1] = 1'b0;
        vld_r[1]    = 1'b0;
        drain();
        chk("abort_once", 32'(abort_seen - start_aborts), 1);

        // Randomized traffic with bubbles and backpressure
        bubble_pct = 20;
        bp_pct     = 30;
        for (int t = 0; t < 2000; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                int r;
                r = $urandom_range(0, N - 1);
                if (src_q[r].size() < 8) push_msg(r, $urandom_range(1, 4), 1'b0);
            end
            cycle();
        end
        drain();
        for (int i = 0; i < N; i++) chk("scoreboard_empty", 32'(exp_q[i].size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
